// File: rtl/mem_bist.sv
// mem_bist: built-in self test for NUM_BANKS identical inferred RAM banks.
// Each run writes a generated pattern (LFSR or increment) to addresses
// 0..addr_max, reads it back through a READ_LATENCY-deep output pipeline and
// compares it against a second generator, repeating for loops+1 passes.
//
// Stream handshakes (start, cfg, status): a word transfers on the rising edge
// where tvalid && tready are both high; the producer holds tvalid and tdata
// stable until that edge; start_tready/cfg_tready depend only on state and
// reset, and status_tvalid depends only on state.
module mem_bist #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 13,
  parameter int NUM_BANKS    = 2,
  parameter int READ_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(32'h8020_0003)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_tvalid,
  output logic                  start_tready,
  input  logic [DATA_WIDTH-1:0] start_tdata,
  input  logic                  cfg_tvalid,
  output logic                  cfg_tready,
  input  logic [31:0]           cfg_tdata,
  input  logic                  fault_inject,
  output logic                  status_tvalid,
  input  logic                  status_tready,
  output logic [31:0]           status_tdata,
  output logic                  error,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  // configuration register
  logic [ADDR_WIDTH-1:0] cfg_addr_max;
  logic [7:0]            cfg_loops;
  logic [NUM_BANKS-1:0]  cfg_bank_en;
  logic                  cfg_mode;

  // run bookkeeping
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            pass_cnt;
  logic [2:0]            drain_cnt;
  logic [DATA_WIDTH-1:0] wr_gen;
  logic [DATA_WIDTH-1:0] exp_gen;

  // status
  logic                  pass_r;
  logic [7:0]            err_cnt;
  logic [15:0]           first_addr;
  logic                  first_seen;

  // read tracking pipeline and compare
  logic                  vld_pipe  [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_pipe [READ_LATENCY];
  logic [NUM_BANKS-1:0]  bank_mis;
  logic                  cmp_valid;
  logic                  mismatch;

  logic start_fire, cfg_fire, addr_last, drain_last;
  logic unused_cfg;

  assign start_tready  = (state == S_IDLE) && !reset;
  assign cfg_tready    = (state == S_IDLE) && !reset;
  assign start_fire    = start_tvalid && start_tready;
  assign cfg_fire      = cfg_tvalid && cfg_tready;
  assign addr_last     = (addr == cfg_addr_max);
  assign drain_last    = (drain_cnt == 3'(READ_LATENCY - 1));
  assign cmp_valid     = vld_pipe[READ_LATENCY-1];
  assign mismatch      = |bank_mis;
  assign status_tvalid = (state == S_DONE);
  assign status_tdata  = {first_addr, err_cnt, 6'b0, (state == S_DONE), pass_r};
  assign state_dbg     = state;
  assign unused_cfg    = ^cfg_tdata;

  // Pattern step: increment in mode 1, Fibonacci LFSR shift-left in mode 0.
  function automatic logic [DATA_WIDTH-1:0] gen_next(input logic [DATA_WIDTH-1:0] d,
                                                     input logic inc);
    logic [DATA_WIDTH-1:0] r;
    if (inc) r = d + DATA_WIDTH'(1);
    else     r = {d[DATA_WIDTH-2:0], ^(d & LFSR_TAPS)};
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_fire) state_nx = S_WRITE;
      S_WRITE: if (addr_last) state_nx = S_READ;
      S_READ:  if (addr_last) state_nx = S_DRAIN;
      S_DRAIN: if (drain_last) state_nx = (pass_cnt != 8'd0) ? S_WRITE : S_DONE;
      S_DONE:  if (status_tready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Config, address/pass counters, generators, read tracking and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_addr_max <= '1;
      cfg_loops    <= 8'd0;
      cfg_bank_en  <= '1;
      cfg_mode     <= 1'b0;
      addr         <= '0;
      pass_cnt     <= 8'd0;
      drain_cnt    <= 3'd0;
      wr_gen       <= '0;
      exp_gen      <= '0;
      pass_r       <= 1'b1;
      err_cnt      <= 8'd0;
      first_addr   <= 16'd0;
      first_seen   <= 1'b0;
      error        <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_pipe[i]  <= 1'b0;
        addr_pipe[i] <= '0;
      end
    end else begin
      if (cfg_fire) begin
        cfg_addr_max <= cfg_tdata[ADDR_WIDTH-1:0];
        cfg_loops    <= cfg_tdata[23:16];
        cfg_bank_en  <= cfg_tdata[24 +: NUM_BANKS];
        cfg_mode     <= cfg_tdata[31];
      end

      // track each issued read down to the compare point
      vld_pipe[0]  <= (state == S_READ);
      addr_pipe[0] <= addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end

      if (cmp_valid) begin
        exp_gen <= gen_next(exp_gen, cfg_mode);
        if (mismatch) begin
          error  <= 1'b1;
          pass_r <= 1'b0;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          if (!first_seen) begin
            first_seen <= 1'b1;
            first_addr <= 16'(addr_pipe[READ_LATENCY-1]);
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (start_fire) begin
            wr_gen     <= start_tdata;
            exp_gen    <= start_tdata;
            pass_cnt   <= cfg_fire ? cfg_tdata[23:16] : cfg_loops;
            addr       <= '0;
            drain_cnt  <= 3'd0;
            pass_r     <= 1'b1;
            err_cnt    <= 8'd0;
            first_addr <= 16'd0;
            first_seen <= 1'b0;
            error      <= 1'b0;
          end
        end
        S_WRITE: begin
          wr_gen <= gen_next(wr_gen, cfg_mode);
          addr   <= addr_last ? '0 : addr + ADDR_WIDTH'(1);
        end
        S_READ: begin
          addr <= addr_last ? '0 : addr + ADDR_WIDTH'(1);
        end
        S_DRAIN: begin
          if (drain_last) begin
            drain_cnt <= 3'd0;
            if (pass_cnt != 8'd0) begin
              pass_cnt <= pass_cnt - 8'd1;
              // next pass restarts both generators where the writes left off
              exp_gen  <= wr_gen;
            end
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem     [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_pipe [READ_LATENCY];
    logic [DATA_WIDTH-1:0] wdata;

    assign wdata = (b == 0 && fault_inject) ? {wr_gen[DATA_WIDTH-1:1], ~wr_gen[0]} : wr_gen;

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
      if (state == S_WRITE && cfg_bank_en[b]) mem[addr] <= wdata;
    end

    // Registered read plus READ_LATENCY-1 output stages.
    always_ff @(posedge clk) begin
      rd_pipe[0] <= mem[addr];
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign bank_mis[b] = cfg_bank_en[b] && (rd_pipe[READ_LATENCY-1] != exp_gen);
  end

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: directed checks of mem_bist timing, pass/loop sequencing,
// fault detection, error saturation, bank masking and mid-run reset.
module tb_mem_bist;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_tvalid, start_tready;
  logic [31:0] start_tdata;
  logic        cfg_tvalid, cfg_tready;
  logic [31:0] cfg_tdata;
  logic        fault_inject;
  logic        status_tvalid, status_tready;
  logic [31:0] status_tdata;
  logic        error;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // clock
  always #5 clk = ~clk;

  mem_bist dut (
    .clk          (clk),
    .reset        (reset),
    .start_tvalid (start_tvalid),
    .start_tready (start_tready),
    .start_tdata  (start_tdata),
    .cfg_tvalid   (cfg_tvalid),
    .cfg_tready   (cfg_tready),
    .cfg_tdata    (cfg_tdata),
    .fault_inject (fault_inject),
    .status_tvalid(status_tvalid),
    .status_tready(status_tready),
    .status_tdata (status_tdata),
    .error        (error),
    .state_dbg    (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // One full run: optional cfg with the start beat, then wait for DONE,
  // check timing/status, accept the status and check the held values.
  // fmode: 0 none, 1 fault only at pass-0 write address 5, 2 fault on every pass-0 write.
  task automatic run_test(input string tag, input bit send_cfg, input logic [31:0] cfg,
                          input logic [31:0] seed, input int fmode, input int amax,
                          input int exp_cyc, input int passes,
                          input logic [31:0] exp_status, input logic exp_err);
    int n;
    int n_write;
    bit seen;
    logic [31:0] e;
    exp_q.push_back(exp_status);
    exp_q.push_back(exp_status & ~32'h2);
    check32({tag, " start_tready"}, 32'(start_tready), 32'd1);
    cfg_tvalid   = send_cfg;
    cfg_tdata    = cfg;
    start_tvalid = 1'b1;
    start_tdata  = seed;
    n = 0;
    n_write = 0;
    seen = 0;
    while (!seen && n < 2000) begin
      tick();
      n++;
      cfg_tvalid   = 1'b0;
      start_tvalid = 1'b0;
      fault_inject = (fmode == 1 && n == 6) || (fmode == 2 && n <= amax + 1);
      if (state_dbg == ST_WRITE) n_write++;
      if (status_tvalid === 1'b1) seen = 1;
    end
    fault_inject = 1'b0;
    check32({tag, " done_cycle"}, 32'(n), 32'(exp_cyc));
    check32({tag, " write_cycles"}, 32'(n_write), 32'(passes * (amax + 1)));
    e = exp_q.pop_front();
    check32({tag, " status"}, status_tdata, e);
    check32({tag, " error"}, 32'(error), 32'(exp_err));
    status_tready = 1'b1;
    tick();
    status_tready = 1'b0;
    check32({tag, " back_idle"}, 32'(state_dbg), 32'(ST_IDLE));
    check32({tag, " status_tvalid_low"}, 32'(status_tvalid), 32'd0);
    e = exp_q.pop_front();
    check32({tag, " status_held"}, status_tdata, e);
    check32({tag, " error_held"}, 32'(error), 32'(exp_err));
  endtask

  initial begin
    reset         = 1'b1;
    start_tvalid  = 1'b0;
    start_tdata   = '0;
    cfg_tvalid    = 1'b0;
    cfg_tdata     = '0;
    fault_inject  = 1'b0;
    status_tready = 1'b0;
    tick();
    tick();
    // reset state
    check32("rst state", 32'(state_dbg), 32'(ST_IDLE));
    check32("rst status_tvalid", 32'(status_tvalid), 32'd0);
    check32("rst status_tdata", status_tdata, 32'h0000_0001);
    check32("rst error", 32'(error), 32'd0);
    check32("rst start_tready", 32'(start_tready), 32'd0);
    reset = 1'b0;
    #1;
    check32("idle start_tready", 32'(start_tready), 32'd1);
    check32("idle cfg_tready", 32'(cfg_tready), 32'd1);
    tick();

    // increment mode, addr_max 15, single pass: DONE at cycle 35
    run_test("t1_inc", 1, 32'h8300_000F, 32'h0000_0100, 0, 15, 35, 1, 32'h0000_0003, 1'b0);
    // LFSR, three passes of 8 words
    run_test("t2_loops", 1, 32'h0302_0007, 32'h0000_0001, 0, 7, 55, 3, 32'h0000_0003, 1'b0);
    // single fault at address 5
    run_test("t3_fault5", 1, 32'h0300_0007, 32'h1234_5678, 1, 7, 19, 1, 32'h0005_0102, 1'b1);
    // 300 faulty words saturate the count; all-zero LFSR pattern
    run_test("t4_sat", 1, 32'h0300_012B, 32'h0000_0000, 2, 299, 603, 1, 32'h0000_FF02, 1'b1);
    // bank 0 masked off, the same fault is invisible
    run_test("t5_mask", 1, 32'h0200_0007, 32'h1234_5678, 1, 7, 19, 1, 32'h0000_0003, 1'b0);

    // standalone cfg beat, then a start that relies on the stored cfg
    cfg_tvalid = 1'b1;
    cfg_tdata  = 32'h0300_0003;
    tick();
    cfg_tvalid = 1'b0;
    check32("t6 cfg_only_idle", 32'(state_dbg), 32'(ST_IDLE));
    run_test("t6_stored_cfg", 0, 32'hFFFF_FFFF, 32'h0000_0000, 0, 3, 11, 1, 32'h0000_0003, 1'b0);

    // reset in the middle of a faulty READ phase
    cfg_tvalid   = 1'b1;
    cfg_tdata    = 32'h8300_000F;
    start_tvalid = 1'b1;
    start_tdata  = 32'h0000_0000;
    for (int n = 1; n <= 22; n++) begin
      tick();
      cfg_tvalid   = 1'b0;
      start_tvalid = 1'b0;
      fault_inject = (n <= 16);
    end
    fault_inject = 1'b0;
    check32("t7 in_read", 32'(state_dbg), 32'(ST_READ));
    check32("t7 error_before", 32'(error), 32'd1);
    check32("t7 busy_tready", 32'(start_tready), 32'd0);
    reset = 1'b1;
    #1;
    check32("t7 rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check32("t7 rst_status_tvalid", 32'(status_tvalid), 32'd0);
    check32("t7 rst_error", 32'(error), 32'd0);
    check32("t7 rst_status_tdata", status_tdata, 32'h0000_0001);
    tick();
    reset = 1'b0;
    tick();
    run_test("t7_rerun", 1, 32'h8300_000F, 32'h0000_0100, 0, 15, 35, 1, 32'h0000_0003, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
